// File: rtl/tile_mort_buf.sv
// tile_mort_buf: receive buffer for a tile's mesh-FIFO delivery port.
//
// Every cycle with outen high delivers a request that cannot be stalled, so
// the buffer captures it unconditionally (if space exists) and hands entries
// in order to the memory/L2 port over a valid/ready handshake. mort_hold warns
// the FIFO early enough to gate outen before the buffer runs out of room.
//
// Optional feature macro: MORTBUF_MERGE_EN -- a non-expunge push whose address
// matches the youngest pending non-expunge entry is merged into that entry
// instead of allocating a new one.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   outen           request valid from tile FIFO (unconditional push)
//   reqmort_data    528-bit line data
//   reqmortaddr     47-bit address {tileY, tileX, addr[36:0]}
//   reqmort_size    12-bit {shared, exclusive, phymsk[9:0]}
//   reqmort_expun   expunge request
//   mort_hold       free entries <= HOLD_LVL
//   mem_valid/ready head-entry handshake
//   mem_data/addr/size/expun  head entry fields
//   ovf_err         sticky: a push was dropped because the buffer was full
module tile_mort_buf #(
    parameter int DEPTH    = 4,
    parameter int HOLD_LVL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         outen,
    input  logic [527:0] reqmort_data,
    input  logic [46:0]  reqmortaddr,
    input  logic [11:0]  reqmort_size,
    input  logic         reqmort_expun,
    output logic         mort_hold,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic [527:0] mem_data,
    output logic [46:0]  mem_addr,
    output logic [11:0]  mem_size,
    output logic         mem_expun,
    output logic         ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [527:0] ent_data  [DEPTH];
    logic [46:0]  ent_addr  [DEPTH];
    logic [11:0]  ent_size  [DEPTH];
    logic         ent_expun [DEPTH];

    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, free;
    logic          pop, full, merge, alloc, drop;

    assign pop  = mem_valid && mem_ready;
    assign full = (cnt == FULL);
    assign free = FULL - cnt;

`ifdef MORTBUF_MERGE_EN
    logic [AW-1:0] young;
    assign young = wp - 1'b1;
    // The youngest entry is the head only when cnt==1; it must not absorb a
    // merge in the same cycle it leaves. A merge into a non-popping head does
    // update the presented fields -- that is the point of merging.
    assign merge = outen && !reqmort_expun && (cnt != '0) && !ent_expun[young] &&
                   (ent_addr[young] == reqmortaddr) &&
                   !(pop && (cnt == (AW+1)'(1)));
`else
    assign merge = 1'b0;
`endif

    // A full buffer can still take a push if the head leaves in the same cycle.
    assign alloc = outen && !merge && (!full || pop);
    assign drop  = outen && !merge && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (alloc) wp <= wp + 1'b1;
            if (pop)   rp <= rp + 1'b1;
            case ({alloc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop) ovf_err <= 1'b1;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by cnt.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_data[wp]  <= reqmort_data;
            ent_addr[wp]  <= reqmortaddr;
            ent_size[wp]  <= reqmort_size;
            ent_expun[wp] <= reqmort_expun;
        end
`ifdef MORTBUF_MERGE_EN
        else if (merge) begin
            ent_data[young] <= reqmort_data;
            ent_size[young] <= {reqmort_size[11:10],
                                ent_size[young][9:0] | reqmort_size[9:0]};
        end
`endif
    end

    assign mem_valid = (cnt != '0);
    assign mort_hold = (int'(free) <= HOLD_LVL);
    assign mem_data  = ent_data[rp];
    assign mem_addr  = ent_addr[rp];
    assign mem_size  = ent_size[rp];
    assign mem_expun = ent_expun[rp];
endmodule

// File: tb/tb_tile_mort_buf.sv
// Directed bench for tile_mort_buf (DEPTH=4, HOLD_LVL=2). Inputs change 1ns
// after the rising edge; outputs are checked there too, well clear of the edge.
module tb_tile_mort_buf;
    logic         clk = 1'b0;
    logic         rst;
    logic         outen;
    logic [527:0] reqmort_data;
    logic [46:0]  reqmortaddr;
    logic [11:0]  reqmort_size;
    logic         reqmort_expun;
    logic         mort_hold, mem_valid, mem_ready;
    logic [527:0] mem_data;
    logic [46:0]  mem_addr;
    logic [11:0]  mem_size;
    logic         mem_expun, ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tile_mort_buf #(.DEPTH(4), .HOLD_LVL(2)) dut (
        .clk(clk), .rst(rst), .outen(outen), .reqmort_data(reqmort_data),
        .reqmortaddr(reqmortaddr), .reqmort_size(reqmort_size),
        .reqmort_expun(reqmort_expun), .mort_hold(mort_hold),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_expun(mem_expun),
        .ovf_err(ovf_err)
    );

    function automatic logic [527:0] pat(input logic [7:0] b);
        return {66{b}};
    endfunction

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic en, input logic [46:0] a, input logic [7:0] d,
                           input logic [11:0] sz, input logic ex);
        outen         = en;
        reqmortaddr   = a;
        reqmort_data  = pat(d);
        reqmort_size  = sz;
        reqmort_expun = ex;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Pop the head each cycle, checking it against consecutive addresses.
    task automatic drain(input string tag, input logic [46:0] first, input int n);
        mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 528'(mem_valid), 528'(1));
            chk({tag, "_addr"}, 528'(mem_addr), 528'(first + 47'(i)));
            step();
        end
        mem_ready = 1'b0;
        chk({tag, "_empty"}, 528'(mem_valid), 528'(0));
    endtask

    initial begin
        int pushed, popped, cyc;
        do_reset();
        chk("rst_valid", 528'(mem_valid), 528'(0));
        chk("rst_hold", 528'(mort_hold), 528'(0));
        chk("rst_ovf", 528'(ovf_err), 528'(0));

        // Single push, latency and stability, then one pop.
        set_req(1'b1, 47'h100, 8'hA5, 12'h005, 1'b0);
        step();
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("p1_valid", 528'(mem_valid), 528'(1));
        chk("p1_addr", 528'(mem_addr), 528'(47'h100));
        chk("p1_data", mem_data, pat(8'hA5));
        step();
        chk("p1_stable_addr", 528'(mem_addr), 528'(47'h100));
        chk("p1_stable_size", 528'(mem_size), 528'(12'h005));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("p1_popped", 528'(mem_valid), 528'(0));

        // Hold threshold, fill, overflow.
        set_req(1'b1, 47'h1, 8'h01, 12'h0, 1'b0);
        step();
        chk("hold_c1", 528'(mort_hold), 528'(0));
        set_req(1'b1, 47'h2, 8'h02, 12'h0, 1'b0);
        step();
        chk("hold_c2", 528'(mort_hold), 528'(1));
        set_req(1'b1, 47'h3, 8'h03, 12'h0, 1'b0);
        step();
        set_req(1'b1, 47'h4, 8'h04, 12'h0, 1'b0);
        step();
        chk("full_no_ovf", 528'(ovf_err), 528'(0));
        set_req(1'b1, 47'h5, 8'h05, 12'h0, 1'b0);
        step();
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("ovf_set", 528'(ovf_err), 528'(1));
        drain("ovf_drain", 47'h1, 4);
        chk("ovf_sticky", 528'(ovf_err), 528'(1));

        // Full buffer with simultaneous push and pop.
        do_reset();
        chk("ovf_cleared", 528'(ovf_err), 528'(0));
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 47'h11 + 47'(i), 8'(i), 12'h0, 1'b0);
            step();
        end
        chk("pp_head0", 528'(mem_addr), 528'(47'h11));
        set_req(1'b1, 47'h15, 8'h15, 12'h0, 1'b0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("pp_ovf", 528'(ovf_err), 528'(0));
        chk("pp_hold", 528'(mort_hold), 528'(1));
        drain("pp_drain", 47'h12, 4);

        // 20 requests, pop on alternate cycles, push gated by mort_hold.
        do_reset();
        pushed = 0;
        popped = 0;
        cyc = 0;
        while (popped < 20 && cyc < 400) begin
            mem_ready = cyc[0];
            if (mem_valid && mem_ready) begin
                chk("stream_addr", 528'(mem_addr), 528'(47'h200 + 47'(popped)));
                chk("stream_data", mem_data, pat(8'(popped + 8'h30)));
                popped++;
            end
            if (pushed < 20 && !mort_hold) begin
                set_req(1'b1, 47'h200 + 47'(pushed), 8'(pushed + 8'h30), 12'h0, 1'b0);
                pushed++;
            end else begin
                set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
            end
            step();
            cyc++;
        end
        mem_ready = 1'b0;
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("stream_count", 528'(popped), 528'(20));
        chk("stream_ovf", 528'(ovf_err), 528'(0));
        chk("stream_empty", 528'(mem_valid), 528'(0));

        // Same-address writes: merged into one entry, or two entries in order.
        do_reset();
        set_req(1'b1, 47'h40, 8'hB1, 12'h003, 1'b0);
        step();
        set_req(1'b1, 47'h40, 8'hB2, 12'h0C0, 1'b0);
        step();
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
`ifdef MORTBUF_MERGE_EN
        chk("mrg_size", 528'(mem_size), 528'(12'h0C3));
        chk("mrg_data", mem_data, pat(8'hB2));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("mrg_one_entry", 528'(mem_valid), 528'(0));
`else
        chk("nomrg_size0", 528'(mem_size), 528'(12'h003));
        chk("nomrg_data0", mem_data, pat(8'hB1));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("nomrg_valid1", 528'(mem_valid), 528'(1));
        chk("nomrg_size1", 528'(mem_size), 528'(12'h0C0));
`endif

        // Expunge never merges.
        do_reset();
        set_req(1'b1, 47'h40, 8'hC1, 12'h000, 1'b1);
        step();
        set_req(1'b1, 47'h40, 8'hC2, 12'h001, 1'b0);
        step();
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("exp_head", 528'(mem_expun), 528'(1));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("exp_second_valid", 528'(mem_valid), 528'(1));
        chk("exp_second_flag", 528'(mem_expun), 528'(0));
        chk("exp_second_data", mem_data, pat(8'hC2));

        // Asynchronous reset with three entries pending.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 47'h60 + 47'(i), 8'(i), 12'h0, 1'b0);
            step();
        end
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("ar_pre_valid", 528'(mem_valid), 528'(1));
        #2 rst = 1'b1;
        #1 chk("ar_async_valid", 528'(mem_valid), 528'(0));
        chk("ar_async_hold", 528'(mort_hold), 528'(0));
        step();
        rst = 1'b0;
        step();
        step();
        chk("ar_no_stale", 528'(mem_valid), 528'(0));
        set_req(1'b1, 47'h77, 8'h77, 12'h0, 1'b0);
        step();
        set_req(1'b0, 47'h0, 8'h00, 12'h0, 1'b0);
        chk("ar_new_addr", 528'(mem_addr), 528'(47'h77));
        drain("ar_drain", 47'h77, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
